// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and requester id types plus default widths for the memory arbiter
package mem_arb_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_WAIT_CYCLES = 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_BOOT, REQ_DM, REQ_IF} req_id_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory bus seen by the arbiter (master) and its peers (slave)
interface mem_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              boot_active, boot_req, boot_ack;
   logic [ADDR_W-1:0] boot_addr;
   logic [DATA_W-1:0] boot_wdata;
   logic              if_req, if_ack;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we, dm_ack;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata, dm_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_cs, mem_we, mem_oe, busy;
   modport master (
      input  boot_active, boot_req, boot_addr, boot_wdata, if_req, if_addr,
             dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output boot_ack, if_ack, if_rdata, dm_ack, dm_rdata,
             mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, busy
   );
   modport slave (
      output boot_active, boot_req, boot_addr, boot_wdata, if_req, if_addr,
             dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  boot_ack, if_ack, if_rdata, dm_ack, dm_rdata,
             mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, busy
   );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses the next requester; boot is exclusive while booting, otherwise DM/IF by pointer (0 = DM first)
module mem_arb_pick import mem_arb_pkg::*; (
   input  logic    boot_active,
   input  logic    boot_req,
   input  logic    if_req,
   input  logic    dm_req,
   input  logic    rr_ptr,
   output req_id_t id
);
   // boot phase masks IF/DM entirely; afterwards boot_req is ignored
   always_comb
      id = boot_active ? (boot_req ? REQ_BOOT : REQ_NONE) :
           (dm_req && if_req) ? (rr_ptr ? REQ_IF : REQ_DM) :
           dm_req ? REQ_DM : if_req ? REQ_IF : REQ_NONE;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the shared memory between boot, IF and DM; define ARB_ROUND_ROBIN_EN to alternate IF/DM grants
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input logic           clock,
   input logic           reset,
   mem_arbiter_if.master bus
);
   localparam int CW = $clog2(WAIT_CYCLES + 1);
   state_t            state, state_n;
   req_id_t           pick, id_q;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
   logic              we_q, rr_ptr, grant, last, acc;
   assign grant = state == IDLE && pick != REQ_NONE;
   assign acc   = state == ACCESS;
   assign last  = acc && cnt == CW'(1);
   mem_arb_pick u_pick (
      .boot_active(bus.boot_active),
      .boot_req   (bus.boot_req),
      .if_req     (bus.if_req),
      .dm_req     (bus.dm_req),
      .rr_ptr     (rr_ptr),
      .id         (pick)
   );
`ifdef ARB_ROUND_ROBIN_EN
   // after each IF/DM grant, favour the other one on the next tie
   always_ff @(posedge clock or negedge reset)
      if (!reset) rr_ptr <= 1'b0;
      else if (grant && pick != REQ_BOOT) rr_ptr <= pick == REQ_DM;
`else
   assign rr_ptr = 1'b0;
`endif
   // next state: grant in IDLE, hold ACCESS for WAIT_CYCLES, one RESP cycle with no arbitration
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (grant) state_n = ACCESS;
         ACCESS:  if (last) state_n = RESP;
         default: state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   // latch the granted operands, count the access down, capture read data on its last cycle
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         id_q       <= REQ_NONE;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (grant) begin
            id_q    <= pick;
            cnt     <= CW'(WAIT_CYCLES);
            addr_q  <= pick == REQ_BOOT ? bus.boot_addr : pick == REQ_DM ? bus.dm_addr : bus.if_addr;
            wdata_q <= pick == REQ_BOOT ? bus.boot_wdata : bus.dm_wdata;
            we_q    <= pick == REQ_BOOT || (pick == REQ_DM && bus.dm_we);
         end else if (acc) cnt <= cnt - 1'b1;
         if (last && !we_q && id_q == REQ_IF) if_rdata_q <= bus.mem_rdata;
         if (last && !we_q && id_q == REQ_DM) dm_rdata_q <= bus.mem_rdata;
      end
   assign bus.mem_cs    = acc;
   assign bus.mem_we    = acc && we_q;
   assign bus.mem_oe    = acc && !we_q;
   assign bus.mem_addr  = acc ? addr_q : '0;
   assign bus.mem_wdata = acc ? wdata_q : '0;
   assign bus.boot_ack  = state == RESP && id_q == REQ_BOOT;
   assign bus.if_ack    = state == RESP && id_q == REQ_IF;
   assign bus.dm_ack    = state == RESP && id_q == REQ_DM;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with WAIT_CYCLES=2 and a small behavioural memory
module tb_mem_arbiter;
   logic clock, reset;
   int   pass, total;
   logic [31:0] mem [0:255];
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
   always @(posedge clock)
      if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

   task automatic do_reset;
      reset = 1'b0;
      bus.boot_active = 0; bus.boot_req = 0; bus.boot_addr = 0; bus.boot_wdata = 0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic dm_store(input logic [31:0] a, input logic [31:0] d);
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = a; bus.dm_wdata = d;
      for (int k = 0; k < 10 && !bus.dm_ack; k++) @(negedge clock);
      total++; if (bus.dm_ack !== 1'b1) $display("FAIL store_timeout got dm_ack=%b exp 1", bus.dm_ack); else pass++;
      bus.dm_req = 0; bus.dm_we = 0;
      @(negedge clock);
   endtask

   task automatic test_reset;
      int acks;
      do_reset;
      total++; if ({bus.busy, bus.boot_ack, bus.if_ack, bus.dm_ack, bus.mem_cs, bus.mem_we, bus.mem_oe} !== 7'b0)
         $display("FAIL reset_ctrl got %b exp 0", {bus.busy, bus.boot_ack, bus.if_ack, bus.dm_ack, bus.mem_cs, bus.mem_we, bus.mem_oe}); else pass++;
      total++; if ({bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata} !== 128'b0)
         $display("FAIL reset_data got %h exp 0", {bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata}); else pass++;
      bus.boot_active = 1; bus.boot_req = 1; bus.boot_addr = 32'h8; bus.boot_wdata = 32'h11111111;
      @(negedge clock);
      total++; if ({bus.mem_cs, bus.busy} !== 2'b11) $display("FAIL pre_abort got cs,busy=%b exp 11", {bus.mem_cs, bus.busy}); else pass++;
      #2 reset = 1'b0;
      #1;
      total++; if ({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.busy, bus.mem_addr, bus.mem_wdata} !== 68'b0)
         $display("FAIL async_abort got %h exp 0", {bus.mem_cs, bus.mem_we, bus.mem_oe, bus.busy, bus.mem_addr, bus.mem_wdata}); else pass++;
      @(negedge clock);
      bus.boot_req = 0; bus.boot_active = 0; reset = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clock);
         if (bus.boot_ack) acks++;
      end
      total++; if (acks !== 0) $display("FAIL abort_ack got %0d acks exp 0", acks); else pass++;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else pass++;
   endtask

   task automatic test_boot_write;
      int if_acks;
      bus.boot_active = 1; bus.boot_req = 1; bus.boot_addr = 32'h4; bus.boot_wdata = 32'hDEADBEEF;
      bus.if_req = 1; bus.if_addr = 32'h40;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k < 3) begin
            total++; if ({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.boot_ack, bus.mem_addr, bus.mem_wdata} !== {4'b1100, 32'h4, 32'hDEADBEEF})
               $display("FAIL boot_access c%0d got %h exp %h", k, {bus.mem_cs, bus.mem_we, bus.mem_oe, bus.boot_ack, bus.mem_addr, bus.mem_wdata}, {4'b1100, 32'h4, 32'hDEADBEEF}); else pass++;
         end else begin
            total++; if ({bus.boot_ack, bus.mem_cs, bus.mem_we} !== 3'b100) $display("FAIL boot_ack got %b exp 100", {bus.boot_ack, bus.mem_cs, bus.mem_we}); else pass++;
            bus.boot_req = 0;
         end
      end
      if_acks = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus.if_ack || bus.busy) if_acks++;
      end
      total++; if (if_acks !== 0) $display("FAIL boot_blocks_if got %0d active cycles exp 0", if_acks); else pass++;
      total++; if (mem[1] !== 32'hDEADBEEF) $display("FAIL boot_mem got %h exp deadbeef", mem[1]); else pass++;
      bus.if_req = 0; bus.boot_active = 0;
      @(negedge clock);
   endtask

   task automatic test_if_read;
      bus.if_req = 1; bus.if_addr = 32'h4;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         if (k < 3) begin
            total++; if ({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.if_ack, bus.mem_addr} !== {4'b1010, 32'h4})
               $display("FAIL if_access c%0d got %h exp %h", k, {bus.mem_cs, bus.mem_we, bus.mem_oe, bus.if_ack, bus.mem_addr}, {4'b1010, 32'h4}); else pass++;
         end else if (k == 3) begin
            total++; if ({bus.if_ack, bus.mem_oe, bus.mem_cs, bus.if_rdata} !== {3'b100, 32'hDEADBEEF})
               $display("FAIL if_ack got %h exp %h", {bus.if_ack, bus.mem_oe, bus.mem_cs, bus.if_rdata}, {3'b100, 32'hDEADBEEF}); else pass++;
            bus.if_req = 0;
         end else begin
            total++; if ({bus.if_ack, bus.mem_oe, bus.if_rdata} !== {2'b00, 32'hDEADBEEF})
               $display("FAIL if_hold got %h exp %h", {bus.if_ack, bus.mem_oe, bus.if_rdata}, {2'b00, 32'hDEADBEEF}); else pass++;
         end
      end
   endtask

   task automatic test_contention;
      int dm_at, if_at;
      logic [31:0] dm_d, if_d;
      dm_store(32'h10, 32'h0BADF00D);
      do_reset;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h10; bus.if_req = 1; bus.if_addr = 32'h4;
      dm_at = 0; if_at = 0; dm_d = 0; if_d = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (bus.dm_ack && dm_at == 0) begin dm_at = k; dm_d = bus.dm_rdata; bus.dm_req = 0; end
         if (bus.if_ack && if_at == 0) begin if_at = k; if_d = bus.if_rdata; bus.if_req = 0; end
      end
      total++; if (dm_at !== 3) $display("FAIL cont_dm_cycle got %0d exp 3", dm_at); else pass++;
      total++; if (if_at !== 7) $display("FAIL cont_if_cycle got %0d exp 7", if_at); else pass++;
      total++; if (dm_d !== 32'h0BADF00D) $display("FAIL cont_dm_data got %h exp 0badf00d", dm_d); else pass++;
      total++; if (if_d !== 32'hDEADBEEF) $display("FAIL cont_if_data got %h exp deadbeef", if_d); else pass++;
   endtask

   task automatic test_store_load;
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h12345678;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k == 1) begin
            total++; if ({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_wdata} !== {3'b110, 32'h20, 32'h12345678})
               $display("FAIL store_access got %h exp %h", {bus.mem_cs, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_wdata}, {3'b110, 32'h20, 32'h12345678}); else pass++;
         end else if (k == 3) begin
            total++; if (bus.dm_ack !== 1'b1) $display("FAIL store_ack got %b exp 1", bus.dm_ack); else pass++;
            bus.dm_req = 0; bus.dm_we = 0; bus.dm_wdata = 0;
         end
      end
      @(negedge clock);
      bus.dm_req = 1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k == 1) begin
            bus.dm_addr = 32'h4;
            total++; if ({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.mem_addr} !== {3'b101, 32'h20})
               $display("FAIL load_access got %h exp %h", {bus.mem_cs, bus.mem_we, bus.mem_oe, bus.mem_addr}, {3'b101, 32'h20}); else pass++;
         end else if (k == 2) begin
            total++; if (bus.mem_addr !== 32'h20) $display("FAIL load_latched got %h exp 20", bus.mem_addr); else pass++;
         end else begin
            total++; if ({bus.dm_ack, bus.dm_rdata} !== {1'b1, 32'h12345678})
               $display("FAIL load_data got %h exp %h", {bus.dm_ack, bus.dm_rdata}, {1'b1, 32'h12345678}); else pass++;
            total++; if (bus.if_rdata !== 32'hDEADBEEF) $display("FAIL load_if_rdata got %h exp deadbeef", bus.if_rdata); else pass++;
            bus.dm_req = 0;
         end
      end
      @(negedge clock);
   endtask

   task automatic test_arbitration;
      int n;
      logic [7:0] got;
      do_reset;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h10; bus.if_req = 1; bus.if_addr = 32'h4;
      n = 0; got = 0;
      repeat (16) begin
         @(negedge clock);
         if (bus.dm_ack) begin n++; got = {got[5:0], 2'b10}; end
         if (bus.if_ack) begin n++; got = {got[5:0], 2'b01}; end
      end
      bus.dm_req = 0; bus.if_req = 0;
      total++; if (n !== 4) $display("FAIL arb_count got %0d exp 4", n); else pass++;
`ifdef ARB_ROUND_ROBIN_EN
      total++; if (got !== 8'b10_01_10_01) $display("FAIL arb_rr_order got %b exp 10011001", got); else pass++;
`else
      total++; if (got !== 8'b10_10_10_10) $display("FAIL arb_fixed_order got %b exp 10101010", got); else pass++;
`endif
      @(negedge clock);
   endtask

   task automatic test_boot_drop;
      do_reset;
      bus.boot_active = 1; bus.boot_req = 1; bus.boot_addr = 32'h30; bus.boot_wdata = 32'h55AA55AA;
      bus.if_req = 1; bus.if_addr = 32'h20;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         if (k == 1) begin
            total++; if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {2'b11, 32'h30})
               $display("FAIL drop_access got %h exp %h", {bus.mem_cs, bus.mem_we, bus.mem_addr}, {2'b11, 32'h30}); else pass++;
            bus.boot_active = 0;
         end else if (k == 3) begin
            total++; if ({bus.boot_ack, bus.if_ack} !== 2'b10) $display("FAIL drop_boot_ack got %b exp 10", {bus.boot_ack, bus.if_ack}); else pass++;
            bus.boot_req = 0;
         end else if (k == 4) begin
            total++; if (bus.busy !== 1'b0) $display("FAIL drop_idle got busy=%b exp 0", bus.busy); else pass++;
         end else if (k == 5) begin
            total++; if ({bus.mem_oe, bus.mem_addr} !== {1'b1, 32'h20})
               $display("FAIL drop_if_access got %h exp %h", {bus.mem_oe, bus.mem_addr}, {1'b1, 32'h20}); else pass++;
         end else if (k == 7) begin
            total++; if ({bus.if_ack, bus.if_rdata} !== {1'b1, 32'h12345678})
               $display("FAIL drop_if_ack got %h exp %h", {bus.if_ack, bus.if_rdata}, {1'b1, 32'h12345678}); else pass++;
            bus.if_req = 0;
         end
      end
      total++; if (mem[12] !== 32'h55AA55AA) $display("FAIL drop_boot_mem got %h exp 55aa55aa", mem[12]); else pass++;
   endtask

   initial begin
      pass = 0; total = 0;
      reset = 1'b0;
      test_reset;
      test_boot_write;
      test_if_read;
      test_contention;
      test_store_load;
      test_arbitration;
      test_boot_drop;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
